move_sched: RTL and testbench

Time-multiplexed scheduler that shares one combinational `move` unit among `NUM_OBJ` object slots. It holds per-object position, subpixel remainder, speed and active flag in an internal register file. On each frame tick it walks the slots in index order, issues each active slot to `move`, and writes the results back. Game logic loads and reads slots through a host port, and a `done_o` pulse marks the end of each frame's physics pass.

---
 rtl/move_sched.sv | 141 ++++++++++++++
 tb/tb_move_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sched.sv
// Time-multiplexed physics scheduler: one combinational move unit shared across NUM_OBJ slots.
// Vector buses pack x in the upper half and y in the lower half (pos 2x16, rem/spd 2x32).
module move_sched #(
    parameter int NUM_OBJ = 4,
    parameter int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_tick_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       overrun_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_pos_i,
    input  logic [63:0]      wr_rem_i,
    input  logic [63:0]      wr_spd_i,
    input  logic             wr_active_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rd_pos_o,
    output logic [63:0]      rd_spd_o,
    output logic             rd_active_o,
    output logic [31:0]      mv_pos_o,
    output logic [63:0]      mv_rem_o,
    output logic [63:0]      mv_spd_o,
    input  logic [31:0]      mv_pos_i,
    input  logic [63:0]      mv_rem_i,
    input  logic [63:0]      mv_spd_i
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WRITEBACK, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               pending_q;
    logic [7:0]         overrun_q;
    logic [31:0]        pos_q [NUM_OBJ];
    logic [63:0]        rem_q [NUM_OBJ];
    logic [63:0]        spd_q [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_q;
    logic               last_slot;
    logic               cur_act;
    logic               tick_busy;

    assign last_slot     = (idx_q == IDX_W'(NUM_OBJ - 1));
    assign cur_act       = act_q[idx_q];
    assign tick_busy     = frame_tick_i && (state_q != S_IDLE);
    assign overrun_cnt_o = overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // A tick that arrived during DONE leaves pending set, so IDLE starts on it too.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (frame_tick_i || pending_q) state_d = S_ISSUE;
            S_ISSUE:     if (cur_act)                   state_d = S_WRITEBACK;
                         else if (last_slot)            state_d = S_DONE;
            S_WRITEBACK: state_d = last_slot ? S_DONE : S_ISSUE;
            S_DONE:      state_d = pending_q ? S_ISSUE : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        wr_ready_o = (state_q == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= '0;
        end else begin
            if (state_d == S_ISSUE && (state_q == S_IDLE || state_q == S_DONE))
                idx_q <= '0;
            else if ((state_q == S_ISSUE && !cur_act && !last_slot) ||
                     (state_q == S_WRITEBACK && !last_slot))
                idx_q <= idx_q + 1'b1;

            if ((state_q == S_DONE || state_q == S_IDLE) && pending_q)
                pending_q <= 1'b0;
            else if (tick_busy)
                pending_q <= 1'b1;

            if (tick_busy && pending_q && overrun_q != 8'hFF)
                overrun_q <= overrun_q + 8'd1;
        end
    end

    // Slot register file: host writes only in IDLE, move results only in WRITEBACK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                pos_q[i] <= '0;
                rem_q[i] <= '0;
                spd_q[i] <= '0;
            end
            act_q <= '0;
        end else if (state_q == S_IDLE && wr_en_i) begin
            pos_q[wr_idx_i] <= wr_pos_i;
            rem_q[wr_idx_i] <= wr_rem_i;
            spd_q[wr_idx_i] <= wr_spd_i;
            act_q[wr_idx_i] <= wr_active_i;
        end else if (state_q == S_WRITEBACK) begin
            pos_q[idx_q] <= mv_pos_i;
            rem_q[idx_q] <= mv_rem_i;
            spd_q[idx_q] <= mv_spd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pos_o    <= '0;
            rd_spd_o    <= '0;
            rd_active_o <= 1'b0;
        end else begin
            rd_pos_o    <= pos_q[rd_idx_i];
            rd_spd_o    <= spd_q[rd_idx_i];
            rd_active_o <= act_q[rd_idx_i];
        end
    end

    // Operand registers stay put through skipped slots so move sees stable inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mv_pos_o <= '0;
            mv_rem_o <= '0;
            mv_spd_o <= '0;
        end else if (state_q == S_ISSUE && cur_act) begin
            mv_pos_o <= pos_q[idx_q];
            mv_rem_o <= rem_q[idx_q];
            mv_spd_o <= spd_q[idx_q];
        end
    end
endmodule

// File: tb/tb_move_sched.sv
// Bench for move_sched: scoreboard of expected done cycles and read-back values,
// produced by a slot-level model of the frame pass using a stub move unit.
module tb_move_sched;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_tick = 1'b0;
    logic        busy, done, wr_ready, rd_active;
    logic [7:0]  overrun;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [1:0]  rd_idx = '0;
    logic [31:0] wr_pos = '0;
    logic [63:0] wr_rem = '0, wr_spd = '0;
    logic        wr_active = 1'b0;
    logic [31:0] rd_pos, mv_pos, mv_pos_ret;
    logic [63:0] rd_spd, mv_rem, mv_spd, mv_rem_ret, mv_spd_ret;

    typedef struct {
        logic [15:0] px, py;
        logic [31:0] rx, ry, sx, sy;
        logic        act;
    } slot_t;
    typedef struct {
        logic [31:0] pos;
        logic [63:0] spd;
        logic        act;
    } rd_exp_t;

    slot_t   m [N];
    rd_exp_t rd_q [$];
    int      done_q [$];
    int      n_cmp = 0, n_fail = 0, cyc = 0;
    bit      sb_on = 1'b1;
    logic    rd_req = 1'b0, rd_pend = 1'b0;

    move_sched #(.NUM_OBJ(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(frame_tick),
        .busy_o(busy), .done_o(done), .overrun_cnt_o(overrun),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_ready_o(wr_ready),
        .wr_pos_i(wr_pos), .wr_rem_i(wr_rem), .wr_spd_i(wr_spd), .wr_active_i(wr_active),
        .rd_idx_i(rd_idx), .rd_pos_o(rd_pos), .rd_spd_o(rd_spd), .rd_active_o(rd_active),
        .mv_pos_o(mv_pos), .mv_rem_o(mv_rem), .mv_spd_o(mv_spd),
        .mv_pos_i(mv_pos_ret), .mv_rem_i(mv_rem_ret), .mv_spd_i(mv_spd_ret)
    );

    // Stub move: pos advances by the integer part of rem, rem accumulates spd, spd bumps by one.
    assign mv_pos_ret = {mv_pos[31:16] + mv_rem[63:48], mv_pos[15:0] + mv_rem[31:16]};
    assign mv_rem_ret = {mv_rem[63:32] + mv_spd[63:32], mv_rem[31:0] + mv_spd[31:0]};
    assign mv_spd_ret = {mv_spd[63:32] + 32'd1, mv_spd[31:0] + 32'd1};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_req;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int      exp_c;
        rd_exp_t r;
        if (rst_n && done && sb_on) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done_o high at cycle %0d, expected none", cyc);
            end else begin
                exp_c = done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(exp_c));
            end
        end
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_underflow: read data with no expectation (cycle %0d)", cyc);
            end else begin
                r = rd_q.pop_front();
                chk("rd_pos", 64'(rd_pos), 64'(r.pos));
                chk("rd_spd", rd_spd, r.spd);
                chk("rd_active", 64'(rd_active), 64'(r.act));
            end
        end
    end

    function automatic slot_t rand_slot();
        slot_t s;
        s.px  = 16'($urandom);
        s.py  = 16'($urandom);
        s.rx  = $urandom;
        s.ry  = $urandom;
        s.sx  = $urandom;
        s.sy  = $urandom;
        s.act = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic cycle1();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_wr(input int i, input slot_t s);
        wr_en     = 1'b1;
        wr_idx    = 2'(i);
        wr_pos    = {s.px, s.py};
        wr_rem    = {s.rx, s.ry};
        wr_spd    = {s.sx, s.sy};
        wr_active = s.act;
    endtask

    task automatic write_slot(input int i, input slot_t s);
        set_wr(i, s);
        cycle1();
        wr_en = 1'b0;
        m[i]  = s;
    endtask

    // One frame of physics over the model; returns active/inactive counts for timing.
    task automatic model_pass(output int a, output int ni);
        a  = 0;
        ni = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i].act) begin
                a++;
                m[i].px = m[i].px + m[i].rx[31:16];
                m[i].py = m[i].py + m[i].ry[31:16];
                m[i].rx = m[i].rx + m[i].sx;
                m[i].ry = m[i].ry + m[i].sy;
                m[i].sx = m[i].sx + 32'd1;
                m[i].sy = m[i].sy + 32'd1;
            end else begin
                ni++;
            end
        end
    endtask

    task automatic start_pass(output int e);
        int a, ni;
        model_pass(a, ni);
        frame_tick = 1'b1;
        cycle1();
        frame_tick = 1'b0;
        wr_en      = 1'b0;
        e          = cyc;
        done_q.push_back(e + 2 * a + ni);
    endtask

    task automatic finish_pass();
        int k = 0;
        while (done_q.size() != 0 && k < 200) begin cycle1(); k++; end
        if (done_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: %0d done pulses still outstanding", done_q.size());
            done_q.delete();
        end
        k = 0;
        while (busy && k < 200) begin cycle1(); k++; end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy_o still 1 expected 0");
        end
    endtask

    task automatic readback_all();
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            rd_req = 1'b1;
            rd_q.push_back('{{m[i].px, m[i].py}, {m[i].sx, m[i].sy}, m[i].act});
            cycle1();
        end
        rd_req = 1'b0;
        cycle1();
        cycle1();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e, e1, d1, d2, a, ni, gaps, k, dones;
        slot_t       s;
        logic [31:0] old0, old2, newp;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rd_pos", 64'(rd_pos), 64'd0);
        chk("rst_mv_pos", 64'(mv_pos), 64'd0);
        chk("rst_mv_spd", mv_spd, 64'd0);
        for (int i = 0; i < N; i++) m[i] = '{default: 0};
        rst_n = 1'b1;
        cycle1();

        // Single active slot at (16,16) with rem of one whole pixel.
        s     = '{default: 0};
        s.px  = 16'd16;
        s.py  = 16'd16;
        s.rx  = 32'h0001_0000;
        s.ry  = 32'h0001_0000;
        s.act = 1'b1;
        write_slot(0, s);
        start_pass(e);
        finish_pass();
        readback_all();

        // Slots 0 and 2 active: operands hold across the skipped slot 1.
        for (int i = 0; i < N; i++) begin
            s     = rand_slot();
            s.act = (i == 0 || i == 2);
            write_slot(i, s);
        end
        old0 = {m[0].px, m[0].py};
        old2 = {m[2].px, m[2].py};
        start_pass(e);
        cycle1();
        cycle1();
        chk("mv_hold_skip", 64'(mv_pos), 64'(old0));
        cycle1();
        chk("mv_hold_issue2", 64'(mv_pos), 64'(old0));
        cycle1();
        chk("mv_slot2", 64'(mv_pos), 64'(old2));
        finish_pass();
        readback_all();

        // Write and tick on the same IDLE edge.
        s     = rand_slot();
        s.act = 1'b1;
        s.sx  = 32'h0001_8000;
        set_wr(0, s);
        m[0] = s;
        start_pass(e);
        cycle1();
        chk("mv_spd_x_same_edge", 64'(mv_spd[63:32]), 64'h0001_8000);
        finish_pass();
        readback_all();

        // Read of a slot on its own writeback edge returns the old position.
        s     = rand_slot();
        s.act = 1'b1;
        s.rx  = 32'h0002_0000;
        s.ry  = 32'h0003_0000;
        write_slot(0, s);
        old0   = {m[0].px, m[0].py};
        rd_idx = 2'd0;
        start_pass(e);
        newp = {m[0].px, m[0].py};
        cycle1();
        cycle1();
        chk("rd_old_on_wb", 64'(rd_pos), 64'(old0));
        cycle1();
        chk("rd_new_after_wb", 64'(rd_pos), 64'(newp));
        finish_pass();

        // Randomized passes, some with a host write attempted mid-pass.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) write_slot(i, rand_slot());
            start_pass(e);
            if (it % 2 == 1) begin
                set_wr($urandom_range(0, N - 1), rand_slot());
                chk("wr_ready_busy", 64'(wr_ready), 64'd0);
                cycle1();
                wr_en = 1'b0;
            end
            finish_pass();
            readback_all();
        end

        // Back-to-back passes from a tick three edges later, then one dropped tick.
        start_pass(e1);
        d1 = done_q[$];
        model_pass(a, ni);
        d2 = d1 + 1 + 2 * a + ni;
        done_q.push_back(d2);
        gaps = 0;
        k    = 0;
        while (cyc <= d2 && k < 100) begin
            if (!busy) gaps++;
            frame_tick = (k == 2 || k == 3);
            cycle1();
            k++;
        end
        frame_tick = 1'b0;
        chk("busy_gap_cycles", 64'(gaps), 64'd0);
        finish_pass();
        chk("overrun_one", 64'(overrun), 64'd1);
        readback_all();

        // Hold the tick for hundreds of cycles to saturate the drop counter.
        sb_on      = 1'b0;
        frame_tick = 1'b1;
        repeat (400) cycle1();
        frame_tick = 1'b0;
        finish_pass();
        chk("overrun_sat", 64'(overrun), 64'd255);
        cycle1();
        done_q.delete();
        sb_on = 1'b1;

        // Reset in the middle of a writeback aborts the pass and clears the slots.
        s     = rand_slot();
        s.act = 1'b1;
        write_slot(0, s);
        start_pass(e);
        cycle1();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        chk("abort_mv_pos", 64'(mv_pos), 64'd0);
        chk("abort_mv_rem", mv_rem, 64'd0);
        chk("abort_rd_spd", rd_spd, 64'd0);
        done_q.delete();
        for (int i = 0; i < N; i++) m[i] = '{default: 0};
        @(negedge clk);
        cycle1();
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            if (done) dones++;
            cycle1();
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        readback_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
